regfile_dump_unit: RTL and testbench

Parametrised hardware register-file dump engine for the pipelined RV32 core. On a start command it scans a programmable range of architectural registers through a dedicated read port and streams {index, value} beats out over a valid/ready interface. Beat consumers are a debug UART, a trace FIFO, or a bench monitor. An optional skip-zero mode and an abort are supported.

---
 rtl/regfile_dump_unit.sv | 129 ++++++++++++
 tb/tb_regfile_dump_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit
//   Scans an inclusive range of architectural registers through a dedicated
//   combinational read port. It streams {index, value} beats over a
//   valid/ready interface. It optionally suppresses registers that read zero,
//   and a running dump can be aborted.
//
// Ports
//   clk, reset               core clock, synchronous active-high reset
//   start, first_idx,        command strobe and inclusive range,
//   last_idx, skip_zero      sampled only in IDLE
//   abort                    drop a running dump (SCAN/DRAIN) back to IDLE
//   rd_addr / rd_data        register-file read port (combinational read)
//   out_valid/out_ready      beat handshake
//   out_idx/out_data         beat payload
//   busy                     high in SCAN and DRAIN
//   done                     1-cycle pulse on normal completion
//   err                      1-cycle pulse on an illegal range
//   beat_count               beats emitted in the current or last dump
module regfile_dump_unit #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_idx,
   input  logic [ADDR_W-1:0] last_idx,
   input  logic              skip_zero,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]   rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_idx,
   output logic [XLEN-1:0]   out_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   beat_count
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NREGS);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] last_q;
   logic              skip_q;

   // The range check is one bit wider so that last_idx < NREGS holds for
   // non-power-of-two register files.
   logic legal;
   logic slot_free;

   assign legal     = (first_idx <= last_idx) && ({1'b0, last_idx} < NREGS_C);
   assign slot_free = !out_valid || out_ready;

   // The read address is the scan pointer itself. rd_data therefore always
   // reflects the current pointer, including re-reads during a stall.
   assign rd_addr = ptr;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         last_q     <= '0;
         skip_q     <= 1'b0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_data   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         beat_count <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               // start takes priority over abort here; abort only matters
               // while a dump is running.
               if (start) begin
                  if (legal) begin
                     ptr        <= first_idx;
                     last_q     <= last_idx;
                     skip_q     <= skip_zero;
                     beat_count <= '0;
                     state      <= SCAN;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (slot_free) begin
                  if (skip_q && rd_data == '0) begin
                     out_valid <= 1'b0;
                  end else begin
                     out_valid  <= 1'b1;
                     out_idx    <= ptr;
                     out_data   <= rd_data;
                     beat_count <= beat_count + (ADDR_W+1)'(1);
                  end
                  // last_q < NREGS is guaranteed at start, so ptr never wraps.
                  if (ptr == last_q) state <= DRAIN;
                  else               ptr   <= ptr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (!(out_valid && !out_ready)) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: full dump, stalled dump, skip-zero,
// illegal range, abort, reset mid-dump, and a single-register range.
module tb_regfile_dump_unit;

   localparam int XLEN = 32, NREGS = 32, AW = 5;

   logic            clk = 1'b0;
   logic            reset, start, skip_zero, abort, out_ready;
   logic [AW-1:0]   first_idx, last_idx, rd_addr, out_idx;
   logic [XLEN-1:0] rd_data, out_data;
   logic            out_valid, busy, done, err;
   logic [AW:0]     beat_count;
   logic [XLEN-1:0] rf [NREGS];

   always #5 clk = ~clk;

   assign rd_data = rf[rd_addr];

   regfile_dump_unit #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .reset(reset), .start(start), .first_idx(first_idx),
      .last_idx(last_idx), .skip_zero(skip_zero), .abort(abort),
      .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
      .busy(busy), .done(done), .err(err), .beat_count(beat_count));

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // cycle counter and passive monitor; all monitor state only grows
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int              q_idx[$];
   logic [XLEN-1:0] q_dat[$];
   int              q_cyc[$];
   int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, busy_cnt = 0;
   int stall_cnt = 0, stab_err = 0;
   logic            prev_stall = 1'b0;
   logic [AW-1:0]   p_idx = '0;
   logic [XLEN-1:0] p_dat = '0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q_idx.push_back(int'(out_idx));
         q_dat.push_back(out_data);
         q_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
      if (busy) busy_cnt++;
      if (prev_stall && !(out_valid && out_idx == p_idx && out_data == p_dat)) stab_err++;
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cnt++;
      p_idx = out_idx;
      p_dat = out_data;
   end

   int s0;

   // Called at posedge+1; start is sampled at the next edge (E0). s0 is the
   // cyc value seen during the cycle right after E0.
   task automatic do_start(input int f, input int l, input logic sk);
      first_idx = AW'(f);
      last_idx  = AW'(l);
      skip_zero = sk;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s0    = cyc;
   endtask

   task automatic wait_done(input string tag, input int base, input int maxc, input bit toggle);
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk); #1;
         if (toggle) out_ready = ~out_ready;
         if (done_cnt > base) break;
      end
      chk(tag, done_cnt - base, 1);
      out_ready = 1'b1;
   endtask

   task automatic preload_x3();
      for (int i = 0; i < NREGS; i++) rf[i] = XLEN'(i * 3);
   endtask

   initial begin
      int qb, db, sb, stb, eb, bb;
      reset = 1'b1; start = 1'b0; skip_zero = 1'b0; abort = 1'b0; out_ready = 1'b1;
      first_idx = '0; last_idx = '0;
      preload_x3();
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_cnt", beat_count, 0);
      chk("rst_rdaddr", rd_addr, 0);
      chk("rst_payload", {out_idx, out_data}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: full dump, always ready
      qb = q_idx.size(); db = done_cnt;
      do_start(0, 31, 1'b0);
      wait_done("t1_done", db, 60, 1'b0);
      chk("t1_nbeats", q_idx.size() - qb, 32);
      for (int k = 0; k < 32; k++) begin
         if (qb + k < q_idx.size()) begin
            chk("t1_idx", q_idx[qb+k], k);
            chk("t1_dat", q_dat[qb+k], k * 3);
         end
      end
      if (q_idx.size() - qb == 32) begin
         chk("t1_first_cyc", q_cyc[qb] - s0, 1);
         chk("t1_contig", q_cyc[qb+31] - q_cyc[qb], 31);
      end
      chk("t1_done_cyc", done_cyc - s0, 33);
      chk("t1_cnt", beat_count, 32);
      chk("t1_busy_after", busy, 0);

      // 2: out_ready toggling
      qb = q_idx.size(); db = done_cnt; stb = stab_err; sb = stall_cnt;
      do_start(0, 31, 1'b0);
      wait_done("t2_done", db, 200, 1'b1);
      chk("t2_nbeats", q_idx.size() - qb, 32);
      for (int k = 0; k < 32; k++) begin
         if (qb + k < q_idx.size()) begin
            chk("t2_idx", q_idx[qb+k], k);
            chk("t2_dat", q_dat[qb+k], k * 3);
         end
      end
      chk("t2_stable", stab_err - stb, 0);
      chk("t2_stalled", (stall_cnt - sb) > 0, 1);
      chk("t2_done_after_last", done_cyc - q_cyc[q_cyc.size()-1], 1);
      chk("t2_cnt", beat_count, 32);

      // 3: skip-zero with two non-zero registers
      for (int i = 0; i < NREGS; i++) rf[i] = '0;
      rf[5] = 32'hDEADBEEF;
      rf[9] = 32'd7;
      qb = q_idx.size(); db = done_cnt;
      do_start(0, 31, 1'b1);
      wait_done("t3_done", db, 60, 1'b0);
      chk("t3_nbeats", q_idx.size() - qb, 2);
      if (q_idx.size() - qb == 2) begin
         chk("t3_b0", {q_idx[qb], q_dat[qb]}, {32'd5, 32'hDEADBEEF});
         chk("t3_b1", {q_idx[qb+1], q_dat[qb+1]}, {32'd9, 32'd7});
      end
      chk("t3_cnt", beat_count, 2);

      // 4: illegal range, then legal 3..10
      preload_x3();
      qb = q_idx.size(); eb = err_cnt; bb = busy_cnt; db = done_cnt;
      do_start(10, 3, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("t4_err_cnt", err_cnt - eb, 1);
      chk("t4_err_cyc", err_cyc - s0, 0);
      chk("t4_no_busy", busy_cnt - bb, 0);
      chk("t4_no_beats", q_idx.size() - qb, 0);
      chk("t4_no_done", done_cnt - db, 0);
      chk("t4_cnt_kept", beat_count, 2);
      do_start(3, 10, 1'b0);
      wait_done("t4b_done", db, 40, 1'b0);
      chk("t4b_nbeats", q_idx.size() - qb, 8);
      for (int k = 0; k < 8; k++) begin
         if (qb + k < q_idx.size()) begin
            chk("t4b_idx", q_idx[qb+k], k + 3);
            chk("t4b_dat", q_dat[qb+k], (k + 3) * 3);
         end
      end
      chk("t4b_cnt", beat_count, 8);

      // 5a: abort once four beats have been captured
      db = done_cnt;
      do_start(0, 31, 1'b0);
      for (int i = 0; i < 20 && beat_count != 4; i++) begin
         @(posedge clk); #1;
      end
      chk("t5_reach4", beat_count, 4);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t5_idle", busy, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_cnt", beat_count, 4);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt - db, 0);
      chk("t5_cnt_hold", beat_count, 4);

      // 5b: reset in the middle of a dump
      db = done_cnt;
      do_start(0, 31, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t5r_outs", {rd_addr, out_valid, out_idx, busy, done, err}, 0);
      chk("t5r_data_cnt", {out_data, beat_count}, 0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t5r_no_done", done_cnt - db, 0);
      chk("t5r_idle", busy, 0);

      // 6: single register, consumer stalled for 5 cycles
      rf[31] = 32'h1234_5678;
      out_ready = 1'b0;
      qb = q_idx.size(); db = done_cnt; sb = stall_cnt; stb = stab_err;
      do_start(31, 31, 1'b0);
      for (int i = 0; i < 10 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("t6_valid", out_valid, 1);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_done("t6_done", db, 10, 1'b0);
      chk("t6_stalls", stall_cnt - sb, 5);
      chk("t6_stable", stab_err - stb, 0);
      chk("t6_nbeats", q_idx.size() - qb, 1);
      if (q_idx.size() - qb == 1) begin
         chk("t6_beat", {q_idx[qb], q_dat[qb]}, {32'd31, 32'h1234_5678});
         chk("t6_done_cyc", done_cyc - q_cyc[qb], 1);
      end
      chk("t6_cnt", beat_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
